// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared funct3 encodings, controller states and widths for the data-memory path
package rv32i_mem_pkg;
  localparam int WORD_W = 32;
  localparam int MASK_W = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
endpackage

// File: rtl/rv32i_lane_align.sv
// rv32i_lane_align: byte-lane masks and store shifting, plus load merge and sign/zero extension
module rv32i_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_funct3,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [WORD_W-1:0] i_r0,
  input  logic [WORD_W-1:0] i_r1,
  output logic [7:0]        o_mask,
  output logic [63:0]       o_data,
  output logic [WORD_W-1:0] o_ext
);
  logic [3:0]        w_size;
  logic [WORD_W-1:0] w_sh;
  logic              w_sx;
  always_comb begin
    w_size = i_funct3[1] ? 4'hF : i_funct3[0] ? 4'h3 : 4'h1;
    o_mask = {4'h0, w_size} << i_off;
`ifdef RV32I_MISALIGN_TRAP_EN
    o_data = {32'h0, i_wdata << {i_off, 3'b000}};
    w_sh   = i_r0 >> {i_off, 3'b000};
`else
    o_data = {32'h0, i_wdata} << {i_off, 3'b000};
    w_sh   = 32'({i_r1, i_r0} >> {i_off, 3'b000});
`endif
    w_sx   = !i_funct3[2];
    o_ext  = i_funct3[1] ? w_sh :
             i_funct3[0] ? {{16{w_sx & w_sh[15]}}, w_sh[15:0]} :
                           {{24{w_sx & w_sh[7]}}, w_sh[7:0]};
  end
endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// rv32i_dmem_ctrl: load/store sequencer driving word-aligned bus beats, splitting straddling accesses.
// Define RV32I_MISALIGN_TRAP_EN to reject misaligned accesses with err instead of splitting them.
module rv32i_dmem_ctrl
  import rv32i_mem_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);
  state_t            r_state;
  logic              r_we, r_err;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [WORD_W-1:0] r_wdata, r_r0, r_r1;
  logic [WAIT_W-1:0] r_cnt;
  logic [1:0]        w_off;
  logic [2:0]        w_f3;
  logic [WORD_W-1:0] w_wdata, w_ext;
  logic [7:0]        w_mask;
  logic [63:0]       w_data;
  logic              w_split, w_illegal, w_trap, w_reject, w_next_beat, w_timeout;
  // In IDLE the lane logic looks at the live request so beat 0 can be registered on acceptance
  assign w_off     = r_state == IDLE ? req_addr[1:0] : r_off;
  assign w_f3      = r_state == IDLE ? req_funct3 : r_f3;
  assign w_wdata   = r_state == IDLE ? req_wdata : r_wdata;
  assign w_split   = |w_mask[7:4];
  assign w_illegal = !(w_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef RV32I_MISALIGN_TRAP_EN
  assign w_trap      = w_split || (w_f3[1:0] == 2'b01 && w_off[0]) || (w_f3[1:0] == 2'b10 && |w_off);
  assign w_next_beat = 1'b0;
`else
  assign w_trap      = 1'b0;
  assign w_next_beat = r_state == BEAT0 && w_split;
`endif
  assign w_reject  = w_illegal || w_trap;
  assign w_timeout = r_cnt == WAIT_W'(MAX_WAIT);
  assign stall     = r_state == IDLE ? req_valid : r_state != RESP;
  assign done      = r_state == RESP;
  assign err       = done && r_err;
  assign load_data = done && !r_we && !r_err ? w_ext : '0;
  rv32i_lane_align u_align (
    .i_off   (w_off),
    .i_funct3(w_f3),
    .i_wdata (w_wdata),
    .i_r0    (r_r0),
    .i_r1    (r_r1),
    .o_mask  (w_mask),
    .o_data  (w_data),
    .o_ext   (w_ext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_wdata   <= '0;
      r_r0      <= '0;
      r_r1      <= '0;
      r_cnt     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we      <= req_we;
          r_f3      <= req_funct3;
          r_off     <= req_addr[1:0];
          r_wdata   <= req_wdata;
          r_cnt     <= '0;
          r_err     <= w_reject;
          r_state   <= w_reject ? RESP : BEAT0;
          mem_req   <= !w_reject;
          mem_we    <= !w_reject && req_we;
          mem_addr  <= {req_addr[31:2], 2'b00};
          mem_wmask <= w_reject || !req_we ? 4'h0 : w_mask[3:0];
          mem_wdata <= w_data[31:0];
        end
        BEAT0, BEAT1: begin
          if (mem_ack && r_state == BEAT0) r_r0 <= mem_rdata;
          if (mem_ack && r_state == BEAT1) r_r1 <= mem_rdata;
          if (mem_ack && w_next_beat) begin
            r_state   <= BEAT1;
            r_cnt     <= '0;
            mem_addr  <= mem_addr + 32'd4;
            mem_wmask <= r_we ? w_mask[7:4] : 4'h0;
            mem_wdata <= w_data[63:32];
          end else if (mem_ack || w_timeout) begin
            r_state   <= RESP;
            r_cnt     <= '0;
            r_err     <= !mem_ack;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// tb_rv32i_dmem_ctrl: random and directed loads/stores against a byte-level memory model with scoreboards
module tb_rv32i_dmem_ctrl;
  localparam int MW = 12;
  typedef struct {logic err; logic [31:0] data; int cyc;} resp_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] mask; logic [31:0] wdata;} beat_t;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, mem_ack = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic stall, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  resp_t rq[$];
  beat_t bq[$];
  int wq[$];
  logic [7:0] ref_mem[logic [31:0]];
  logic [7:0] bus_mem[logic [31:0]];
  logic [2:0] lf[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  bit rb_busy = 0;
  int rb_cnt = 0, rb_k = 0;
  beat_t rb_b;
  logic [31:0] rb_a;
  resp_t mon_r;

  rv32i_dmem_ctrl #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_b(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
  endfunction
  function automatic logic [7:0] bus_rd(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_b(a);
  endfunction
  function automatic int pick_wait();
    int r = int'($urandom_range(0, 19));
    return r < 14 ? int'($urandom_range(0, 3)) : r < 17 ? MW : MW + 1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_word(logic [31:0] a, logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[a + 32'(i)] = w[i*8 +: 8];
      bus_mem[a + 32'(i)] = w[i*8 +: 8];
    end
  endtask

  task automatic chk_quiet(string name);
    chk({name, "_ctrl"}, {stall, done, err, mem_req, mem_we, mem_wmask}, 0);
    chk({name, "_load_data"}, load_data, 0);
    chk({name, "_bus"}, {mem_addr, mem_wdata}, 0);
  endtask

  // Issue one op; kf0/kf1 force the ack wait of each beat (negative means random, > MW means never ack)
  task automatic do_op(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, int kf0, int kf1);
    int size, nb, k, t, dc, lane, bi;
    bit ill, to, got;
    logic [3:0] m[2];
    logic [31:0] wv[2];
    logic [31:0] v, ba;
    resp_t r;
    beat_t b;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    t = cyc;
    size = f3[1] ? 4 : f3[0] ? 2 : 1;
    nb = (int'(a[1:0]) + size > 4) ? 2 : 1;
    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef RV32I_MISALIGN_TRAP_EN
    if (nb == 2 || (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00)) ill = 1;
`endif
    m[0] = 0; m[1] = 0; wv[0] = 0; wv[1] = 0; v = 0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      bi = (ba[31:2] != a[31:2]) ? 1 : 0;
      lane = int'(ba[1:0]);
      m[bi][lane] = 1'b1;
      wv[bi][lane*8 +: 8] = wd[i*8 +: 8];
      v[i*8 +: 8] = ref_rd(ba);
    end
    if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
    if (ill) begin
      r.err = 1; r.data = 0; r.cyc = t + 1;
    end else begin
      dc = t + 1; to = 0;
      for (int j = 0; j < nb && !to; j++) begin
        k = (j == 0) ? kf0 : kf1;
        if (k < 0) k = pick_wait();
        wq.push_back(k);
        if (k > MW) begin
          to = 1; dc += MW + 1;
        end else begin
          dc += k + 1;
          b.addr = {a[31:2], 2'b00} + 32'(4 * j); b.we = we; b.mask = we ? m[j] : 4'h0; b.wdata = wv[j];
          bq.push_back(b);
          if (we) for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            if (((ba[31:2] != a[31:2]) ? 1 : 0) == j) ref_mem[ba] = wd[i*8 +: 8];
          end
        end
      end
      r.err = to; r.data = (to || we) ? 32'h0 : v; r.cyc = dc;
    end
    rq.push_back(r);
    got = 0;
    for (int c = 0; c < 4 * MW + 40 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    req_valid = 0;
    if (!got) begin
      chk("done_wait", 0, 1);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      rq.delete(); wq.delete(); bq.delete();
    end
  endtask

  // Reset while the second beat of a split load is outstanding
  task automatic rst_mid();
    beat_t b;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h103; req_wdata = 0;
    wq.push_back(0); wq.push_back(MW + 1);
    b.addr = 32'h100; b.we = 0; b.mask = 0; b.wdata = 0;
    bq.push_back(b);
    repeat (2) @(negedge clk);
    chk("beat1_addr_before_rst", {mem_req, mem_addr}, {1'b1, 32'h104});
    rst = 1; req_valid = 0;
    @(negedge clk);
    chk_quiet("rst_mid");
    rst = 0;
    wq.delete(); bq.delete();
  endtask

  // Bus responder: acks after the wait chosen by the stimulus and checks the beat at ack time
  initial forever begin
    @(negedge clk);
    mem_ack = 0;
    if (!mem_req || rst) rb_busy = 0;
    else begin
      if (!rb_busy) begin
        if (wq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
          rb_k = 0;
        end else rb_k = wq.pop_front();
        rb_busy = 1; rb_cnt = 0;
      end
      if (rb_cnt == rb_k) begin
        mem_ack = 1; rb_busy = 0;
        for (int i = 0; i < 4; i++) mem_rdata[i*8 +: 8] = bus_rd(mem_addr + 32'(i));
        if (bq.size() == 0) chk("beat_missing", 1, 0);
        else begin
          rb_b = bq.pop_front();
          chk("beat_addr", mem_addr, rb_b.addr);
          chk("beat_we", mem_we, rb_b.we);
          chk("beat_mask", mem_wmask, rb_b.mask);
          for (int i = 0; i < 4; i++) if (rb_b.mask[i]) chk("beat_wdata_lane", mem_wdata[i*8 +: 8], rb_b.wdata[i*8 +: 8]);
        end
        if (mem_we) for (int i = 0; i < 4; i++) if (mem_wmask[i]) begin
          rb_a = mem_addr + 32'(i);
          bus_mem[rb_a] = mem_wdata[i*8 +: 8];
        end
      end else rb_cnt++;
    end
  end

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (done) begin
      if (rq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_r = rq.pop_front();
        chk("done_cycle", cyc, mon_r.cyc);
        chk("err", err, mon_r.err);
        chk("load_data", load_data, mon_r.data);
        chk("stall_in_resp", stall, 0);
      end
    end
  end

  initial begin
    set_word(32'h200, 32'h80FFFFFF);
    set_word(32'hFFFFFFFC, 32'hAABBCCDD);
    set_word(32'h0, 32'h11223344);
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 0;
    do_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, -1);
    do_op(0, 3'b000, 32'h203, 32'h0, 1, -1);
    do_op(0, 3'b100, 32'h203, 32'h0, 0, -1);
    do_op(1, 3'b001, 32'h7, 32'h1234, 0, 2);
    do_op(0, 3'b001, 32'h7, 32'h0, 0, 0);
    do_op(0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 0);
    do_op(0, 3'b010, 32'h100, 32'h0, MW + 1, -1);
    do_op(0, 3'b010, 32'h100, 32'h0, MW, -1);
    do_op(1, 3'b010, 32'h102, 32'hCAFEF00D, 0, MW + 1);
    do_op(0, 3'b011, 32'h100, 32'h0, -1, -1);
    do_op(1, 3'b111, 32'h104, 32'h55, -1, -1);
    rst_mid();
    for (int n = 0; n < 300; n++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) f3 = ($urandom_range(0, 2) == 0) ? 3'b011 : ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = lf[$urandom_range(0, 4)];
      a = ($urandom_range(0, 3) != 0) ? 32'h100 + 32'($urandom_range(0, 31)) : 32'hFFFFFFF8 + 32'($urandom_range(0, 11));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(we, f3, a, $urandom(), -1, -1);
    end
    repeat (3) @(negedge clk);
    chk("responses_left", rq.size(), 0);
    chk("beats_left", bq.size(), 0);
    chk("waits_left", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
